niosii_pio_in: RTL and testbench
================================

NIOSII_PIO_IN -- requirements
Module: niosii_pio_in

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, input port width (1..32).
REQ-002 SHALL provide parameter EDGE_TYPE, default 0, edge detected: 0 rising, 1 falling, 2 any.
REQ-003 SHALL provide parameter IRQ_TYPE, default 1, interrupt source: 0 level (synchronized data), 1 edge (edge capture register).
REQ-004 SHALL have port clk  input  1  system clock; all registers on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port read_n  input  1  read strobe, active-low.
REQ-009 SHALL have port write_n  input  1  write strobe, active-low.
REQ-010 SHALL have port writedata  input  32  write data.
REQ-011 SHALL have port in_port  input  WIDTH  asynchronous external inputs.
REQ-012 SHALL have port readdata  output  32  registered read data.
REQ-013 SHALL have port irq  output  1  interrupt request, active-high.

Function
REQ-014 SHALL pass in_port through a 2-flop synchronizer (sync1, sync2); sync2 is the data value.
REQ-015 SHALL keep data_prev, a one-cycle-delayed copy of sync2.
REQ-016 SHALL detect per bit: rising = sync2 & ~data_prev; falling = ~sync2 & data_prev; any = sync2 ^ data_prev, per EDGE_TYPE.
REQ-017 SHALL set edge_capture bit on a detected edge; bit stays set (sticky) until cleared by software.
REQ-018 Latency: in_port change settled before clock edge k SHALL appear in sync2 after edge k+1 and in edge_capture after edge k+2.
REQ-019 Register map: addr 0 data (RO, sync2), addr 2 irq_mask (RW, WIDTH bits), addr 3 edge_capture (read; write-1-to-clear), other addresses read 0, writes ignored.
REQ-020 Write strobe = chipselect & ~write_n; writes take effect on the same clock edge.
REQ-021 Write to addr 3 SHALL clear each edge_capture bit whose writedata bit is 1; bits written 0 unchanged.
REQ-022 Edge detected on a bit in the same cycle as its clear SHALL leave that bit set (set wins; no lost edge).
REQ-023 Write to addr 0 SHALL be ignored; writedata bits above WIDTH-1 ignored.
REQ-024 readdata SHALL be registered: on each clock with chipselect & ~read_n, readdata <= zero-extended mux(address); otherwise readdata holds; read latency 1 cycle.
REQ-025 Read and write in same cycle to addr 3 SHALL return pre-write edge_capture value.
REQ-026 IRQ_TYPE 1: irq = OR(edge_capture & irq_mask); IRQ_TYPE 0: irq = OR(sync2 & irq_mask); irq derived only from registers (glitch-free).
REQ-027 irq SHALL deassert the cycle after the last masked capture bit is cleared or its mask bit written 0.
REQ-028 Inputs SHALL not be sampled combinationally anywhere except through sync1.

Reset
REQ-029 reset_n low SHALL asynchronously clear sync1, sync2, data_prev, edge_capture, irq_mask, readdata to 0; irq 0.
REQ-030 Reset deassertion SHALL be used synchronously; in_port high at reset release with EDGE_TYPE 0 SHALL produce a rising-edge capture (data_prev resets to 0).
REQ-031 Reset mid-operation SHALL discard pending edges and captured state; no spurious irq during reset.

Verification
REQ-032 WIDTH 8, EDGE_TYPE 0: in_port 0x00->0x05, read addr 3 after 3 cycles -> readdata 0x05; read addr 0 -> 0x05.
REQ-033 irq_mask=0x04, capture 0x05 -> irq 1; write 0x04 to addr 3 -> capture 0x01, irq 0 next cycle.
REQ-034 Rising edge on bit 1 same cycle as write 0x02 to addr 3 -> bit 1 remains set, irq per mask.
REQ-035 EDGE_TYPE 1: in_port 0xFF->0xF0 -> capture 0x0F; 0xF0->0xFF produces no new capture.
REQ-036 IRQ_TYPE 0, mask 0x80: in_port bit 7 high -> irq 1 after 2 cycles, low -> irq 0 after 2 cycles.
REQ-037 Assert reset_n low with capture 0xFF, mask 0xFF -> irq, readdata, capture 0 immediately; read addr 5 -> 0.

Source files
------------

// File: rtl/niosii_pio_in.sv
// Avalon-MM parallel input port: synchronizer, edge capture, interrupt mask.
// Edges are sticky until cleared by writing 1s to the capture register.
module niosii_pio_in #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int IRQ_TYPE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] data_prev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             rd_en;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_edge;

  assign rd_en   = chipselect & ~read_n;
  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en && (address == ADDR_MASK);
  assign wr_edge = wr_en && (address == ADDR_EDGE);
  assign wdata   = writedata[WIDTH-1:0];
  assign clr     = wr_edge ? wdata : '0;

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  // in_port is only ever observed through sync1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      data_prev <= '0;
    end else begin
      sync1     <= in_port;
      sync2     <= sync1;
      data_prev <= sync2;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edges = sync2 & ~data_prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edges = ~sync2 & data_prev;
    end else begin : g_any
      assign edges = sync2 ^ data_prev;
    end
  endgenerate

  // Set wins over a simultaneous clear so no edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr) | edges;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_mask) begin
      irq_mask <= wdata;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = sync2;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_mux;
    end
  end

  generate
    if (IRQ_TYPE == 0) begin : g_irq_level
      assign irq = |(sync2 & irq_mask);
    end else begin : g_irq_edge
      assign irq = |(edge_capture & irq_mask);
    end
  endgenerate

endmodule

// File: tb/tb_niosii_pio_in.sv
// Directed bench for niosii_pio_in: rising/falling/any edge capture,
// level and edge interrupts, register map, reset behaviour.
module tb_niosii_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_a, in_b, in_c, in_d;
  logic [31:0] rd_a, rd_b, rd_c, rd_d;
  logic        irq_a, irq_b, irq_c, irq_d;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  niosii_pio_in dut_a (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a)
  );

  niosii_pio_in #(.EDGE_TYPE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b)
  );

  niosii_pio_in #(.IRQ_TYPE(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c)
  );

  niosii_pio_in #(.EDGE_TYPE(2)) dut_d (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .in_port(in_d), .readdata(rd_d), .irq(irq_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    tick(1);
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    tick(3);
    chk("reset_readdata", rd_a, 32'h0);
    chk("reset_irq", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;
    tick(3);

    // rising capture and latency boundary
    in_a = 8'h05;
    in_b = 8'hFF;
    tick(2);
    rd(3'd3);
    chk("cap_not_yet", rd_a, 32'h0);
    rd(3'd3);
    chk("cap_rise", rd_a, 32'h05);
    chk("fall_ignores_rise", rd_b, 32'h0);
    rd(3'd0);
    chk("data_read", rd_a, 32'h05);
    tick(2);
    chk("readdata_holds", rd_a, 32'h05);

    // mask and write-1-to-clear
    wr(3'd2, 32'h04);
    chk("irq_masked_set", {31'h0, irq_a}, 32'h1);
    wr(3'd3, 32'h04);
    chk("irq_after_clear", {31'h0, irq_a}, 32'h0);
    rd(3'd3);
    chk("cap_after_clear", rd_a, 32'h01);

    // edge on bit 1 lands on the same edge as its clear
    in_a = 8'h07;
    tick(2);
    wr(3'd3, 32'h02);
    rd(3'd3);
    chk("set_wins", rd_a, 32'h03);
    chk("irq_unmasked_bit", {31'h0, irq_a}, 32'h0);
    wr(3'd2, 32'hFFFF_FF02);
    chk("irq_new_mask", {31'h0, irq_a}, 32'h1);
    rd(3'd2);
    chk("mask_upper_ignored", rd_a, 32'h02);

    // simultaneous read and clear returns pre-write value
    address    = 3'd3;
    writedata  = 32'hFF;
    chipselect = 1'b1;
    read_n     = 1'b0;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    chk("rw_prewrite", rd_a, 32'h03);
    chk("irq_rw_cleared", {31'h0, irq_a}, 32'h0);
    rd(3'd3);
    chk("cap_rw_cleared", rd_a, 32'h0);

    // data is read-only; unmapped addresses
    wr(3'd0, 32'h00);
    rd(3'd0);
    chk("data_ro", rd_a, 32'h07);
    wr(3'd5, 32'hFF);
    rd(3'd5);
    chk("unmapped_rd", rd_a, 32'h0);
    rd(3'd2);
    chk("unmapped_wr", rd_a, 32'h02);

    // falling-edge instance and any-edge instance
    in_b = 8'hF0;
    in_d = 8'h3C;
    tick(3);
    rd(3'd3);
    chk("fall_cap", rd_b, 32'h0F);
    chk("fall_irq", {31'h0, irq_b}, 32'h1);
    chk("any_rise", rd_d, 32'h3C);
    wr(3'd3, 32'hFF);
    in_b = 8'hFF;
    in_d = 8'h30;
    tick(3);
    rd(3'd3);
    chk("fall_no_rise", rd_b, 32'h0);
    chk("any_fall", rd_d, 32'h0C);

    // level interrupt
    wr(3'd2, 32'h80);
    in_c = 8'h80;
    tick(1);
    chk("lvl_irq_1cyc", {31'h0, irq_c}, 32'h0);
    tick(1);
    chk("lvl_irq_2cyc", {31'h0, irq_c}, 32'h1);
    in_c = 8'h00;
    tick(1);
    chk("lvl_drop_1cyc", {31'h0, irq_c}, 32'h1);
    tick(1);
    chk("lvl_drop_2cyc", {31'h0, irq_c}, 32'h0);

    // full capture, then asynchronous reset mid-operation
    in_a = 8'h00;
    tick(3);
    in_a = 8'hFF;
    tick(3);
    wr(3'd2, 32'hFF);
    rd(3'd3);
    chk("cap_full", rd_a, 32'hFF);
    chk("irq_full", {31'h0, irq_a}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_readdata", rd_a, 32'h0);
    chk("rst_irq", {31'h0, irq_a}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    rd(3'd3);
    chk("rst_cap_cleared", rd_a, 32'h0);
    tick(2);
    rd(3'd3);
    chk("cap_at_release", rd_a, 32'hFF);
    chk("irq_mask_reset", {31'h0, irq_a}, 32'h0);
    rd(3'd2);
    chk("mask_reset", rd_a, 32'h0);
    rd(3'd5);
    chk("rst_addr5", rd_a, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
